// File: rtl/ethernet_tx_arbiter.sv
// Frame-level arbiter merging two 64-bit AXI-stream sources onto the MAC tx stream.
// Optional per-source frame and abort counters are enabled with `define TX_ARB_STATS_EN.
module ethernet_tx_arbiter #(
  parameter int PRIORITY_MODE  = 0,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        s0_axis_tvalid,
  input  logic [63:0] s0_axis_tdata,
  input  logic        s0_axis_tlast,
  input  logic [7:0]  s0_axis_tkeep,
  output logic        s0_axis_tready,
  input  logic        s1_axis_tvalid,
  input  logic [63:0] s1_axis_tdata,
  input  logic        s1_axis_tlast,
  input  logic [7:0]  s1_axis_tkeep,
  output logic        s1_axis_tready,
  output logic        m_axis_tvalid,
  output logic [63:0] m_axis_tdata,
  output logic        m_axis_tlast,
  output logic [7:0]  m_axis_tkeep,
  input  logic        m_axis_tready,
  output logic [1:0]  o_grant,
  output logic        o_busy,
  output logic        o_abort
`ifdef TX_ARB_STATS_EN
  ,
  output logic [15:0] o_s0_frames,
  output logic [15:0] o_s1_frames,
  output logic [15:0] o_aborts
`endif
);

  typedef enum logic [2:0] {IDLE, GRANT0, GRANT1, ABORT, FLUSH} state_t;

  localparam logic [15:0] TIMEOUT = 16'(TIMEOUT_CYCLES);

  state_t      state, state_nx;
  logic        src, src_nx;              // owner of the current frame (0 = s0, 1 = s1)
  logic        last_s1, last_s1_nx;      // round-robin pointer: last frame came from s1
  logic        started, started_nx;
  logic [15:0] cnt, cnt_nx;
  logic        abort_nx;

  logic        sel_valid, sel_last;
  logic [63:0] sel_data;
  logic [7:0]  sel_keep;
  logic [15:0] cnt_inc;

  assign sel_valid = src ? s1_axis_tvalid : s0_axis_tvalid;
  assign sel_last  = src ? s1_axis_tlast  : s0_axis_tlast;
  assign sel_data  = src ? s1_axis_tdata  : s0_axis_tdata;
  assign sel_keep  = src ? s1_axis_tkeep  : s0_axis_tkeep;
  assign cnt_inc   = cnt + 16'd1;
  assign o_busy    = (state != IDLE);

  // NOTE: every signal assigned here gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_nx       = state;
    src_nx         = src;
    last_s1_nx     = last_s1;
    started_nx     = started;
    cnt_nx         = cnt;
    abort_nx       = 1'b0;
    s0_axis_tready = 1'b0;
    s1_axis_tready = 1'b0;
    m_axis_tvalid  = 1'b0;
    m_axis_tdata   = '0;
    m_axis_tlast   = 1'b0;
    m_axis_tkeep   = '0;
    o_grant        = 2'b00;

    case (state)
      IDLE: begin
        started_nx = 1'b0;
        cnt_nx     = '0;
        if (s0_axis_tvalid && (!s1_axis_tvalid || PRIORITY_MODE == 1 || last_s1)) begin
          state_nx = GRANT0;
          src_nx   = 1'b0;
        end else if (s1_axis_tvalid) begin
          state_nx = GRANT1;
          src_nx   = 1'b1;
        end
      end

      GRANT0, GRANT1: begin
        o_grant        = src ? 2'b10 : 2'b01;
        m_axis_tvalid  = sel_valid;
        m_axis_tdata   = sel_data;
        m_axis_tlast   = sel_last;
        m_axis_tkeep   = sel_keep;
        s0_axis_tready = !src && m_axis_tready;
        s1_axis_tready = src && m_axis_tready;
        if (sel_valid) begin
          // A present beat always clears the stall counter, even on the expiry cycle.
          cnt_nx = '0;
          if (m_axis_tready) begin
            started_nx = 1'b1;
            if (sel_last) begin
              state_nx   = IDLE;
              last_s1_nx = src;
            end
          end
        end else if (started) begin
          cnt_nx = cnt_inc;
          if (cnt_inc == TIMEOUT) begin
            state_nx = ABORT;
            abort_nx = 1'b1;
          end
        end
      end

      ABORT: begin
        o_grant       = src ? 2'b10 : 2'b01;
        m_axis_tvalid = 1'b1;
        m_axis_tlast  = 1'b1;
        if (m_axis_tready) state_nx = FLUSH;
      end

      FLUSH: begin
        o_grant        = src ? 2'b10 : 2'b01;
        s0_axis_tready = !src;
        s1_axis_tready = src;
        if (sel_valid && sel_last) begin
          state_nx   = IDLE;
          last_s1_nx = src;
        end
      end

      default: state_nx = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of block evaluation order.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state   <= IDLE;
      src     <= 1'b0;
      last_s1 <= 1'b1;
      started <= 1'b0;
      cnt     <= '0;
      o_abort <= 1'b0;
    end else begin
      state   <= state_nx;
      src     <= src_nx;
      last_s1 <= last_s1_nx;
      started <= started_nx;
      cnt     <= cnt_nx;
      o_abort <= abort_nx;
    end
  end

`ifdef TX_ARB_STATS_EN
  logic s0_done, s1_done;

  assign s0_done = (state == GRANT0) && (state_nx == IDLE);
  assign s1_done = (state == GRANT1) && (state_nx == IDLE);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_s0_frames <= '0;
      o_s1_frames <= '0;
      o_aborts    <= '0;
    end else begin
      if (s0_done && o_s0_frames != 16'hFFFF) o_s0_frames <= o_s0_frames + 16'd1;
      if (s1_done && o_s1_frames != 16'hFFFF) o_s1_frames <= o_s1_frames + 16'd1;
      if (abort_nx && o_aborts != 16'hFFFF)   o_aborts    <= o_aborts + 16'd1;
    end
  end
`endif

endmodule
